// File: rtl/l1d_ewrq_wb_sender_pkg.sv
// Shared definitions for the L1D eviction write-back sender: MESI encodings,
// write-back message types, EWRQ meta layout and NoC header layout.
package l1d_ewrq_wb_sender_pkg;

  localparam int L1D_BANK_LINE_ADDR_SIZE = 14;
  localparam int LINE_W                  = 512;
  localparam int META_W                  = 16;
  localparam int META_ADDR_LSB           = 0;
  localparam int META_MESI_LSB           = L1D_BANK_LINE_ADDR_SIZE;
  localparam int HDR_TYPE_W              = 2;
  localparam int HDR_MESI_W              = 2;
  localparam int HDR_W                   = HDR_TYPE_W + L1D_BANK_LINE_ADDR_SIZE + HDR_MESI_W;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  typedef enum logic [1:0] {
    WB_DIRTY = 2'b01,
    WB_CLEAN = 2'b10
  } wb_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WAIT_ACK,
    ST_POP
  } wb_state_e;

  // Header bits before MSB alignment into the flit: {type, addr, mesi}.
  function automatic logic [HDR_W-1:0] wb_hdr_bits(input wb_type_e                           t,
                                                   input logic [L1D_BANK_LINE_ADDR_SIZE-1:0] addr,
                                                   input mesi_e                              m);
    return {t, addr, m};
  endfunction

endpackage

// File: rtl/l1d_ewrq_wb_sender.sv
// Serialises the EWRQ head entry into NoC write-back flits toward L2 and pops
// the entry only once L2 has acknowledged the write-back.
module l1d_ewrq_wb_sender
  import l1d_ewrq_wb_sender_pkg::*;
#(
  parameter int FLIT_W    = 128,
  parameter int ACK_TO_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ewrq_vld_i,
  input  logic [15:0]       ewrq_meta_i,
  input  logic [511:0]      ewrq_line_i,
  output logic              ewrq_deq_o,
  output logic              flit_vld_o,
  output logic [FLIT_W-1:0] flit_o,
  output logic              flit_head_o,
  output logic              flit_tail_o,
  input  logic              flit_rdy_i,
  input  logic              ack_vld_i,
  output logic              busy_o,
  output logic              spur_ack_o,
  output logic [15:0]       wb_dirty_cnt_o
);

  localparam int NBEAT  = LINE_W / FLIT_W;
  localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  if ((ACK_TO_EN != 0) || ((LINE_W % FLIT_W) != 0) || (FLIT_W < HDR_W)) begin : g_bad_cfg
    $error("l1d_ewrq_wb_sender: unsupported FLIT_W/ACK_TO_EN configuration");
  end

  wb_state_e             r_state;
  wb_state_e             w_next;
  logic [META_W-1:0]     r_meta;
  logic [LINE_W-1:0]     r_line;
  logic [BEAT_W-1:0]     r_beat;
  logic                  r_spur;
  logic [15:0]           r_cnt;

  logic                  w_fire;
  logic                  w_dirty;
  logic                  w_last;
  mesi_e                 w_in_mesi;
  mesi_e                 w_lat_mesi;
  logic [FLIT_W-1:0]     w_hdr;

  assign w_in_mesi  = mesi_e'(ewrq_meta_i[META_MESI_LSB +: 2]);
  assign w_lat_mesi = mesi_e'(r_meta[META_MESI_LSB +: 2]);
  assign w_dirty    = (w_lat_mesi == MESI_M);
  assign w_last     = (r_beat == BEAT_W'(NBEAT - 1));
  assign w_fire     = flit_vld_o & flit_rdy_i;
  assign w_hdr      = FLIT_W'(wb_hdr_bits(w_dirty ? WB_DIRTY : WB_CLEAN,
                                          r_meta[META_ADDR_LSB +: L1D_BANK_LINE_ADDR_SIZE],
                                          w_lat_mesi)) << (FLIT_W - HDR_W);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (ewrq_vld_i) w_next = (w_in_mesi == MESI_I) ? ST_POP : ST_HDR;
      ST_HDR:      if (w_fire) w_next = w_dirty ? ST_DATA : ST_WAIT_ACK;
      ST_DATA:     if (w_fire && w_last) w_next = ST_WAIT_ACK;
      ST_WAIT_ACK: if (ack_vld_i) w_next = ST_POP;
      ST_POP:      w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The entry is captured once so later MESI updates at the EWRQ head cannot alter an in-flight packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_line <= '0;
    end else if ((r_state == ST_IDLE) && ewrq_vld_i) begin
      r_meta <= ewrq_meta_i;
      r_line <= ewrq_line_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= '0;
    end else if (r_state != ST_DATA) begin
      r_beat <= '0;
    end else if (w_fire) begin
      r_beat <= r_beat + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spur <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (ack_vld_i && (r_state != ST_WAIT_ACK)) r_spur <= 1'b1;
      if (ack_vld_i && (r_state == ST_WAIT_ACK) && w_dirty && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // Flit outputs decode only from registered state, so they stay put while the NoC stalls.
  always_comb begin
    flit_vld_o  = 1'b0;
    flit_head_o = 1'b0;
    flit_tail_o = 1'b0;
    flit_o      = '0;
    case (r_state)
      ST_HDR: begin
        flit_vld_o  = 1'b1;
        flit_head_o = 1'b1;
        flit_tail_o = ~w_dirty;
        flit_o      = w_hdr;
      end
      ST_DATA: begin
        flit_vld_o  = 1'b1;
        flit_tail_o = w_last;
        flit_o      = r_line[32'(r_beat) * FLIT_W +: FLIT_W];
      end
      default: ;
    endcase
  end

  assign ewrq_deq_o     = (r_state == ST_POP);
  assign busy_o         = (r_state != ST_IDLE);
  assign spur_ack_o     = r_spur;
  assign wb_dirty_cnt_o = r_cnt;

endmodule
